// File: rtl/seg_display_front.sv
// Display front end: latches a CPU byte, commits it on the falling scan-clock
// tick, and drives decoded segment words. SEG_BLINK_EN builds the blink timer.
module seg_display_front #(
    parameter int DIV_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        ctrl_wr,
    input  logic [3:0]  ctrl_data,
    output logic        scan_clk,
    output logic [11:0] low,
    output logic [11:0] high,
    output logic        pending
);

    logic [DIV_WIDTH-1:0] cnt;
    logic [7:0]           shadow;
    logic [7:0]           disp;
    logic                 blank;
    logic                 dp_low;
    logic                 dp_high;
    logic                 tick;
    logic                 commit;
    logic                 blink_off;
    logic                 dark;
    logic [11:0]          low_next;
    logic [11:0]          high_next;

    function automatic logic [11:0] decode(input logic [3:0] nib);
        logic [11:0] seg;
        unique case (nib)
            4'h0: seg = 12'hF50;
            4'h1: seg = 12'h600;
            4'h2: seg = 12'hE68;
            4'h3: seg = 12'hE28;
            4'h4: seg = 12'h638;
            4'h5: seg = 12'hB38;
            4'h6: seg = 12'hB78;
            4'h7: seg = 12'hE00;
            4'h8: seg = 12'hF78;
            4'h9: seg = 12'hF38;
            4'hA: seg = 12'hE78;
            4'hB: seg = 12'h378;
            4'hC: seg = 12'h950;
            4'hD: seg = 12'h668;
            4'hE: seg = 12'h978;
            default: seg = 12'h878;
        endcase
        return seg;
    endfunction

    assign tick   = &cnt;
    // Falling scan edge is the only safe point to swap the displayed pair
    assign commit = tick & scan_clk & pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            scan_clk <= 1'b0;
        end else begin
            cnt <= cnt + 1'b1;
            if (tick)
                scan_clk <= ~scan_clk;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            disp    <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_en)
                shadow <= wr_data;
            if (commit) begin
                disp    <= wr_en ? wr_data : shadow;
                pending <= 1'b0;
            end else if (wr_en) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank   <= 1'b0;
            dp_low  <= 1'b0;
            dp_high <= 1'b0;
        end else if (ctrl_wr) begin
            blank   <= ctrl_data[0];
            dp_low  <= ctrl_data[2];
            dp_high <= ctrl_data[3];
        end
    end

`ifdef SEG_BLINK_EN
    logic       blink;
    logic [7:0] blink_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink     <= 1'b0;
            blink_cnt <= '0;
        end else begin
            if (ctrl_wr)
                blink <= ctrl_data[1];
            if (tick)
                blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_off = blink & blink_cnt[7];
`else
    logic unused_blink;

    assign unused_blink = ctrl_data[1];
    assign blink_off    = 1'b0;
`endif

    assign dark = blank | blink_off;

    always_comb begin
        low_next  = decode(disp[3:0]) | {9'b0, dp_low, 2'b00};
        high_next = decode(disp[7:4]) | {9'b0, dp_high, 2'b00};
        if (dark) begin
            low_next  = 12'h000;
            high_next = 12'h000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            low  <= 12'hF50;
            high <= 12'hF50;
        end else begin
            low  <= low_next;
            high <= high_next;
        end
    end

endmodule

// File: tb/tb_seg_display_front.sv
// Directed bench for seg_display_front with DIV_WIDTH=2 (scan period 8 clk).
// Blink expectations follow SEG_BLINK_EN when the bench is built with it.
module tb_seg_display_front;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        ctrl_wr = 1'b0;
    logic [3:0]  ctrl_data = 4'h0;
    logic        scan_clk;
    logic [11:0] low;
    logic [11:0] high;
    logic        pending;

    int total = 0;
    int bad = 0;

    seg_display_front #(.DIV_WIDTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .ctrl_wr   (ctrl_wr),
        .ctrl_data (ctrl_data),
        .scan_clk  (scan_clk),
        .low       (low),
        .high      (high),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Park just after the edge where scan_clk fell
    task automatic sync_fall();
        logic prev;
        bit   found;
        found = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            prev = scan_clk;
            step();
            if (prev === 1'b1 && scan_clk === 1'b0)
                found = 1;
        end
        total++;
        if (!found) begin
            bad++;
            $display("FAIL sync_fall: scan_clk falling edge not seen in 40 clk");
        end
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (low !== 12'hF50 || high !== 12'hF50) begin
            bad++;
            $display("FAIL reset_out: low=%h high=%h want F50 F50", low, high);
        end
        total++;
        if (scan_clk !== 1'b0 || pending !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: scan=%b pend=%b want 0 0",
                     scan_clk, pending);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step();
        total++;
        if (scan_clk !== 1'b0) begin
            bad++;
            $display("FAIL scan_e3: got %b want 0", scan_clk);
        end
        step();
        total++;
        if (scan_clk !== 1'b1) begin
            bad++;
            $display("FAIL scan_e4: got %b want 1", scan_clk);
        end
        repeat (3) step();
        total++;
        if (scan_clk !== 1'b1) begin
            bad++;
            $display("FAIL scan_e7: got %b want 1", scan_clk);
        end
        step();
        total++;
        if (scan_clk !== 1'b0) begin
            bad++;
            $display("FAIL scan_e8: got %b want 0", scan_clk);
        end
    endtask

    task automatic test_write();
        sync_fall();
        wr_en = 1'b1;
        wr_data = 8'h5A;
        step();
        wr_en = 1'b0;
        total++;
        if (pending !== 1'b1 || low !== 12'hF50 || high !== 12'hF50) begin
            bad++;
            $display("FAIL wr_held: pend=%b low=%h high=%h want 1 F50 F50",
                     pending, low, high);
        end
        repeat (6) step();
        total++;
        if (pending !== 1'b1 || scan_clk !== 1'b1) begin
            bad++;
            $display("FAIL wr_wait: pend=%b scan=%b want 1 1",
                     pending, scan_clk);
        end
        step();
        total++;
        if (pending !== 1'b0 || low !== 12'hF50) begin
            bad++;
            $display("FAIL wr_commit: pend=%b low=%h want 0 F50",
                     pending, low);
        end
        step();
        total++;
        if (high !== 12'hB38 || low !== 12'hE78) begin
            bad++;
            $display("FAIL wr_out: high=%h low=%h want B38 E78", high, low);
        end
    endtask

    task automatic test_back_to_back();
        sync_fall();
        wr_en = 1'b1;
        wr_data = 8'h12;
        step();
        wr_en = 1'b0;
        step();
        wr_en = 1'b1;
        wr_data = 8'h34;
        step();
        wr_en = 1'b0;
        repeat (4) step();
        total++;
        if (pending !== 1'b1 || low !== 12'hE78 || high !== 12'hB38) begin
            bad++;
            $display("FAIL b2b_hold: pend=%b low=%h high=%h want 1 E78 B38",
                     pending, low, high);
        end
        wr_en = 1'b1;
        wr_data = 8'h99;
        step();
        wr_en = 1'b0;
        total++;
        if (pending !== 1'b0) begin
            bad++;
            $display("FAIL b2b_pend: got %b want 0", pending);
        end
        step();
        total++;
        if (low !== 12'hF38 || high !== 12'hF38) begin
            bad++;
            $display("FAIL b2b_bypass: low=%h high=%h want F38 F38", low, high);
        end
        repeat (10) step();
        total++;
        if (pending !== 1'b0 || low !== 12'hF38 || high !== 12'hF38) begin
            bad++;
            $display("FAIL b2b_stable: pend=%b low=%h high=%h want 0 F38 F38",
                     pending, low, high);
        end
    endtask

    task automatic test_ctrl();
        sync_fall();
        wr_en = 1'b1;
        wr_data = 8'h88;
        step();
        wr_en = 1'b0;
        repeat (8) step();
        total++;
        if (low !== 12'hF78 || high !== 12'hF78) begin
            bad++;
            $display("FAIL ctrl_base: low=%h high=%h want F78 F78", low, high);
        end
        ctrl_wr = 1'b1;
        ctrl_data = 4'b1100;
        step();
        ctrl_wr = 1'b0;
        total++;
        if (low !== 12'hF78) begin
            bad++;
            $display("FAIL ctrl_lat: low=%h want F78", low);
        end
        step();
        total++;
        if (low !== 12'hF7C || high !== 12'hF7C) begin
            bad++;
            $display("FAIL ctrl_dp: low=%h high=%h want F7C F7C", low, high);
        end
        ctrl_wr = 1'b1;
        ctrl_data = 4'b0001;
        step();
        ctrl_wr = 1'b0;
        step();
        total++;
        if (low !== 12'h000 || high !== 12'h000) begin
            bad++;
            $display("FAIL ctrl_blank: low=%h high=%h want 000 000", low, high);
        end
        ctrl_wr = 1'b1;
        ctrl_data = 4'b0100;
        wr_en = 1'b1;
        wr_data = 8'h21;
        step();
        ctrl_wr = 1'b0;
        wr_en = 1'b0;
        step();
        total++;
        if (low !== 12'hF7C || high !== 12'hF78 || pending !== 1'b1) begin
            bad++;
            $display("FAIL ctrl_simul: low=%h high=%h pend=%b want F7C F78 1",
                     low, high, pending);
        end
    endtask

    task automatic test_blink();
        int bad_val;
        int changes;
        int bad_int;
        int last;
        logic [11:0] prev;
        sync_fall();
        step();
        total++;
        if (low !== 12'h604 || high !== 12'hE68) begin
            bad++;
            $display("FAIL blink_pre: low=%h high=%h want 604 E68", low, high);
        end
        ctrl_wr = 1'b1;
        ctrl_data = 4'b0010;
        step();
        ctrl_wr = 1'b0;
        step();
        bad_val = 0;
        changes = 0;
        bad_int = 0;
        last = 0;
        prev = low;
        for (int i = 0; i < 1100; i++) begin
            step();
            if (!((low === 12'h600 && high === 12'hE68) ||
                  (low === 12'h000 && high === 12'h000)))
                bad_val++;
            if (low !== prev) begin
                if (changes > 0 && i - last != 512)
                    bad_int++;
                changes++;
                last = i;
            end
            prev = low;
        end
        total++;
        if (bad_val != 0) begin
            bad++;
            $display("FAIL blink_val: %0d bad cycles want 0", bad_val);
        end
`ifdef SEG_BLINK_EN
        total++;
        if (changes < 2 || bad_int != 0) begin
            bad++;
            $display("FAIL blink_phase: changes=%0d badint=%0d want >=2 0",
                     changes, bad_int);
        end
        for (int i = 0; i < 600 && low !== 12'h000; i++)
            step();
        total++;
        if (low !== 12'h000) begin
            bad++;
            $display("FAIL blink_off: low=%h want 000", low);
        end
`else
        total++;
        if (changes != 0 || low !== 12'h600) begin
            bad++;
            $display("FAIL blink_static: changes=%0d low=%h want 0 600",
                     changes, low);
        end
`endif
        ctrl_wr = 1'b1;
        ctrl_data = 4'b0000;
        step();
        ctrl_wr = 1'b0;
        step();
        total++;
        if (low !== 12'h600 || high !== 12'hE68) begin
            bad++;
            $display("FAIL blink_clear: low=%h high=%h want 600 E68",
                     low, high);
        end
    endtask

    task automatic test_reset_mid();
        int drift;
        sync_fall();
        wr_en = 1'b1;
        wr_data = 8'h77;
        step();
        wr_en = 1'b0;
        total++;
        if (pending !== 1'b1) begin
            bad++;
            $display("FAIL rst_pre: pend=%b want 1", pending);
        end
        repeat (2) step();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (pending !== 1'b0 || low !== 12'hF50 || high !== 12'hF50 ||
            scan_clk !== 1'b0) begin
            bad++;
            $display("FAIL rst_async: pend=%b low=%h high=%h scan=%b",
                     pending, low, high, scan_clk);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drift = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (pending !== 1'b0 || low !== 12'hF50 || high !== 12'hF50)
                drift++;
        end
        total++;
        if (drift != 0) begin
            bad++;
            $display("FAIL rst_discard: %0d cycles off reset value want 0",
                     drift);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_ctrl();
        test_blink();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
